ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Shares one single-port command-driven RAM between two requesters. Each requester issues simple read/write transactions as an address, write enable and data. The block arbitrates round-robin and serialises each transaction into the RAM's 10-bit command stream: 00 = write address, 01 = write data, 10 = read address, 11 = read fetch. For reads it captures the RAM's tx_valid/dout response and returns it to the granted requester.

Parameters:
ADDR_SIZE, 8, RAM address width; command word is ADDR_SIZE+2 bits.
TIMEOUT, 4, maximum WAIT cycles allowed for tx_valid before a read completes with err.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req  in  2  per-client request level; bit k = client k
we  in  2  per-client write enable; 1 = write, 0 = read
addr  in  2*ADDR_SIZE  per-client address; client k in slice [k*ADDR_SIZE +: ADDR_SIZE]
wdata  in  16  per-client write data; client k in [k*8 +: 8]
done  out  2  one-cycle completion pulse to the granted client
rdata  out  8  read data; valid only while done is high on a read
err  out  1  read timeout flag; valid only while done is high
busy  out  1  high whenever the FSM is not in IDLE
ram_din  out  ADDR_SIZE+2  command word to the RAM
ram_rx_valid  out  1  command-word valid to the RAM
ram_tx_valid  in  1  RAM read-response valid
ram_dout  in  8  RAM read data

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE; done = 0, rdata = 0, err = 0, busy = 0.
  - ram_rx_valid = 0, ram_din = 0.
  - Round-robin pointer = client 0.
  - Reset mid-transaction aborts the transaction: no done pulse, and ram_rx_valid is 0 from the next cycle.
- Outputs are decoded from the state and latched transaction registers only. There is no combinational path from req/we/addr/wdata to any output.
- States: IDLE, ADDR, DATA, WAIT, DONE.
- IDLE:
  - If any req is high, select a client: when both are high, the pointer's client wins; otherwise the single requester wins.
  - Latch that client's index, we, addr and wdata, then go to ADDR.
  - With no request, ram_rx_valid = 0.
- ADDR (1 cycle):
  - ram_rx_valid = 1.
  - ram_din = {2'b00, addr} for a write, {2'b10, addr} for a read.
  - Next state: DATA.
- DATA (1 cycle):
  - ram_rx_valid = 1.
  - ram_din = {2'b01, wdata} for a write, {2'b11, 8'h00} for a read.
  - Next state: DONE for a write, WAIT for a read.
- WAIT:
  - ram_rx_valid = 0 and ram_din = 0.
  - Counter starts at 0 on entry.
  - ram_tx_valid sampled as exactly 1: capture ram_dout into rdata, set err = 0, go to DONE.
  - Counter reaches TIMEOUT-1 without tx_valid: set rdata = 0, err = 1, go to DONE.
  - Any non-1 value on ram_tx_valid (0, z, x) counts as not valid.
- DONE (1 cycle):
  - done[granted] = 1; rdata/err hold the result (rdata = 0, err = 0 for writes).
  - ram_rx_valid = 0.
  - Pointer moves to the other client; next state IDLE.
- Latency from the req-sampling edge to the done cycle:
  - Write: done in cycle 3 (ADDR c1, DATA c2, DONE c3).
  - Read with a normal RAM: done in cycle 4 (WAIT c3 sees tx_valid).
- Minimum spacing: back-to-back transactions are separated by one IDLE cycle.
- Requester contract:
  - Fields are latched at grant; later changes to addr/wdata/we have no effect on the in-flight transaction.
  - Deasserting req after grant does not cancel the transaction; done still pulses.
  - Requesters must drop req in the done cycle to avoid a repeat transaction.
- Fairness: with both clients requesting continuously, grants alternate 0,1,0,1. No client waits more than one transaction.
- busy = 1 in ADDR, DATA, WAIT and DONE.

Decomposition:
- Shared package holds:
  - Command opcode constants: CMD_WADDR = 2'b00, CMD_WDATA = 2'b01, CMD_RADDR = 2'b10, CMD_RDATA = 2'b11.
  - State encoding constants.
- One natural sub-module: rr_arbiter2. It is the two-request round-robin priority pick plus the pointer register, with an advance input pulsed in DONE.
- FSM, latches and timeout counter stay in the top module.

Test Plan:
- Write then read, same client: client 0 writes addr 0x3C, data 0xA5, then reads 0x3C.
  - RAM sees 0x03C, 0x1A5, then 0x23C, 0x300.
  - done[0] pulses at cycle 3 (write), then read done with rdata = 0xA5, err = 0, 4 cycles after the read's req-sampling edge.
- Simultaneous requests: both clients request from reset (client 0 writes 0x11, client 1 writes 0x22).
  - Client 0 is granted first, client 1 second.
  - done order is [0] then [1], with 4 cycles between done pulses.
- Continuous contention: both req held high for 6 transactions.
  - Grant order is 0,1,0,1,0,1.
  - Transaction streams never interleave within one transaction.
- Read timeout: model RAM holds tx_valid = 0 (then drives z).
  - After 4 WAIT cycles, done pulses with err = 1 and rdata = 0x00.
- Reset mid-operation: assert rst_n = 0 during DATA of a write.
  - No done pulse; ram_rx_valid = 0 and busy = 0 next cycle.
  - After release, a new request starts with client 0 priority.
- Field stability: change addr/wdata and drop req one cycle after grant.
  - RAM still receives the originally latched words, and done pulses once.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the two-client RAM port arbiter: RAM command opcodes and FSM states.
// Pure definitions: no latency, no backpressure.
package ram_port_arbiter_pkg;

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_RDATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick; the pointer names the client that wins a tie.
// Grant is combinational from req_i; the pointer only moves when advance_i pulses.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       adv_idx_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_vld_o = |req_i;
        gnt_idx_o = (&req_i) ? ptr_q : req_i[1];
        ptr_d     = ptr_q;
        // After serving a client, the other one gets priority on the next tie.
        if (advance_i) begin
            ptr_d = ~adv_idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a command-driven single-port RAM between two clients, serialising each transaction into address/data words.
// Write done 3 cycles after grant, read 4+ (bounded by TIMEOUT); one IDLE cycle between transactions, no input backpressure.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [2*ADDR_SIZE-1:0] addr_i,
    input  logic [15:0]            wdata_i,
    output logic [1:0]             done_o,
    output logic [7:0]             rdata_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [ADDR_SIZE+1:0]   ram_din_o,
    output logic                   ram_rx_valid_o,
    input  logic                   ram_tx_valid_i,
    input  logic [7:0]             ram_dout_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic                   client_q, client_d;
    logic                   we_q, we_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   gnt_vld;
    logic                   gnt_idx;
    logic                   advance;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .advance_i (advance),
        .adv_idx_i (client_q),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d        = state_q;
        client_d       = client_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        advance        = 1'b0;
        ram_rx_valid_o = 1'b0;
        ram_din_o      = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    client_d = gnt_idx;
                    we_d     = we_i[gnt_idx];
                    addr_d   = gnt_idx ? addr_i[2*ADDR_SIZE-1:ADDR_SIZE] : addr_i[ADDR_SIZE-1:0];
                    wdata_d  = gnt_idx ? wdata_i[15:8] : wdata_i[7:0];
                    rdata_d  = 8'h00;
                    err_d    = 1'b0;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                ram_rx_valid_o = 1'b1;
                ram_din_o      = {(we_q ? CMD_WADDR : CMD_RADDR), addr_q};
                state_d        = ST_DATA;
            end
            ST_DATA: begin
                ram_rx_valid_o = 1'b1;
                ram_din_o      = we_q ? {CMD_WDATA, ADDR_SIZE'(wdata_q)}
                                      : {CMD_RDATA, {ADDR_SIZE{1'b0}}};
                cnt_d          = '0;
                state_d        = we_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // X/Z on tx_valid falls through to the not-valid branch.
                if (ram_tx_valid_i) begin
                    rdata_d = ram_dout_i;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                advance = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            client_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 8'h00;
            cnt_q    <= '0;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            client_q <= client_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign done_o  = (state_q == ST_DONE) ? (client_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM plus a transaction-level reference (pick rule, latency, memory contents).
module tb_ram_port_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic        tx_v;
    logic [7:0]  tx_d;

    int checks = 0;
    int errors = 0;

    // Reference state: tie-break owner and expected memory contents.
    int       ptr = 0;
    bit [7:0] ref_mem [256] = '{default: 8'h00};

    // Behavioural RAM controls.
    int       rd_delay = 0;
    bit       noresp   = 1'b0;
    logic     idle_tv  = 1'b0;
    bit [7:0] ram_mem [256] = '{default: 8'h00};
    bit [7:0] waddr_r = 8'h00;
    bit [7:0] raddr_r = 8'h00;
    int       rcnt = -1;

    ram_port_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .done_o         (done),
        .rdata_o        (rdata),
        .err_o          (err),
        .busy_o         (busy),
        .ram_din_o      (ram_din),
        .ram_rx_valid_o (ram_rx_valid),
        .ram_tx_valid_i (tx_v),
        .ram_dout_i     (tx_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: a fetch answered with delay d raises tx_valid in the d-th cycle after the fetch word.
    always @(posedge clk) begin
        tx_v <= idle_tv;
        tx_d <= 8'($urandom);
        if (rcnt == 0) begin
            tx_v <= 1'b1;
            tx_d <= ram_mem[raddr_r];
        end
        if (rcnt >= 0) rcnt <= rcnt - 1;
        if (ram_rx_valid === 1'b1) begin
            case (ram_din[9:8])
                2'b00: waddr_r <= ram_din[7:0];
                2'b01: ram_mem[waddr_r] <= ram_din[7:0];
                2'b10: raddr_r <= ram_din[7:0];
                default: begin
                    if (!noresp) begin
                        if (rd_delay == 0) begin
                            tx_v <= 1'b1;
                            tx_d <= ram_mem[raddr_r];
                        end else begin
                            rcnt <= rd_delay - 1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit [1:0] r);
        if (r == 2'b11) return ptr;
        return r[1] ? 1 : 0;
    endfunction

    // Called at a negedge with the DUT in IDLE. mode 0: drop req in done cycle,
    // 1: hold req, 2: drop req and scramble fields one cycle after grant.
    task automatic run(input bit [1:0] r, input bit [1:0] w, input bit [7:0] a0, input bit [7:0] a1,
                       input bit [7:0] d0, input bit [7:0] d1, input int dly, input bit nr, input int mode);
        int         c, lat, nw;
        bit         cw;
        bit [7:0]   ca, cd, erd;
        bit         eerr;
        logic [9:0] got [4];
        logic [9:0] e0, e1;
        req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
        rd_delay = dly; noresp = nr;
        c  = pick(r);
        cw = w[c];
        ca = (c == 1) ? a1 : a0;
        cd = (c == 1) ? d1 : d0;
        if (cw) begin
            e0 = {2'b00, ca}; e1 = {2'b01, cd};
            lat = 3; erd = 8'h00; eerr = 1'b0;
            ref_mem[ca] = cd;
        end else begin
            e0 = {2'b10, ca}; e1 = 10'h300;
            if (nr) begin
                lat = 3 + TIMEOUT; erd = 8'h00; eerr = 1'b1;
            end else begin
                lat = 4 + dly; erd = ref_mem[ca]; eerr = 1'b0;
            end
        end
        nw = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (mode == 2 && k == 1) begin
                req = 2'b00; we = ~we; addr = 16'($urandom); wdata = 16'($urandom);
            end
            if (ram_rx_valid === 1'b1) begin
                if (nw < 4) got[nw] = ram_din;
                nw++;
            end
            if (k < lat) begin
                chk("done_early", 32'(done), 32'd0);
                chk("busy_active", 32'(busy), 32'd1);
            end else if (k == lat) begin
                chk("done_pulse", 32'(done), 32'(2'b01 << c));
                chk("rdata", 32'(rdata), 32'(erd));
                chk("err", 32'(err), 32'(eerr));
                chk("busy_done", 32'(busy), 32'd1);
                ptr = (c == 0) ? 1 : 0;
                if (mode != 1) req = 2'b00;
            end else begin
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_rxv", 32'(ram_rx_valid), 32'd0);
            end
        end
        chk("word_count", 32'(nw), 32'd2);
        if (nw >= 2) begin
            chk("word0", 32'(got[0]), 32'(e0));
            chk("word1", 32'(got[1]), 32'(e1));
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = 16'h0; wdata = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rxv", 32'(ram_rx_valid), 32'd0);
        chk("rst_din", 32'(ram_din), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1; ptr = 0;

        // Simultaneous requests from reset: client 0 first, then client 1.
        run(2'b11, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 0, 1'b0, 1);
        run(2'b11, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 0, 1'b0, 0);

        // Write then read back, same client.
        run(2'b01, 2'b01, 8'h3C, 8'h00, 8'hA5, 8'h00, 0, 1'b0, 0);
        run(2'b01, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 0, 1'b0, 0);

        // Continuous contention, six transactions.
        for (int i = 0; i < 6; i++) begin
            run(2'b11, 2'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                8'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT - 1), 1'b0, (i == 5) ? 0 : 1);
        end

        // Read timeouts: tx_valid held 0, then floating.
        run(2'b10, 2'b00, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 1'b1, 0);
        idle_tv = 1'bz;
        run(2'b01, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 0, 1'b1, 0);
        idle_tv = 1'b0;

        // Field stability: req dropped and fields changed after grant.
        run(2'b10, 2'b10, 8'h00, 8'h5E, 8'h00, 8'h6B, 0, 1'b0, 2);
        run(2'b10, 2'b00, 8'h00, 8'h5E, 8'h00, 8'h00, 2, 1'b0, 2);

        // Reset during DATA of a write, with the pointer favouring client 1 beforehand.
        run(2'b01, 2'b01, 8'h40, 8'h00, 8'h5A, 8'h00, 0, 1'b0, 0);
        req = 2'b01; we = 2'b01; addr = 16'h0077; wdata = 16'h00C3;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_word", 32'(ram_din), 32'h1C3);
        rst_n = 1'b0; req = 2'b00;
        ref_mem[8'h77] = 8'hC3;
        @(negedge clk);
        chk("rst_mid_rxv", 32'(ram_rx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("rst_hold_done", 32'(done), 32'd0);
        rst_n = 1'b1; ptr = 0;
        run(2'b11, 2'b10, 8'h21, 8'h77, 8'h99, 8'h00, 1, 1'b0, 0);

        // Randomised mix against the reference.
        for (int i = 0; i < 24; i++) begin
            run(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                8'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT - 1),
                ($urandom_range(0, 7) == 0), 2 * $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
